pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges three hazard sources into one consistent set of per-stage write enables and flushes:
- load-use data hazards detected in ID;
- taken branches resolved in ID;
- multi-cycle data-memory accesses in MEM, driven by a req/ack handshake.

It also watches for a memory timeout and keeps stall and flush performance counters.

Parameters:
MAX_WAIT, 255, maximum cycles a MEM access may wait for mem_ack_i before the block enters ERROR (1..2^WAIT_W-1)
WAIT_W, 8, width of the internal wait counter
CNT_W, 32, width of stall_cnt_o and flush_cnt_o (saturating)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  pipeline run enable
ID_EX_MemRead_i  in  1  instruction in EX is a load
ID_EX_RegisterRt_i  in  5  load destination register in EX
IF_ID_RegisterRs_i  in  5  Rs of instruction in ID
IF_ID_RegisterRt_i  in  5  Rt of instruction in ID
branch_taken_i  in  1  branch in ID resolved taken
EX_MEM_MemAccess_i  in  1  instruction in MEM performs load/store
mem_ack_i  in  1  data memory completes current access (1-cycle pulse)
mem_req_o  out  1  data memory access request
PC_Write_o  out  1  1 = PC updates
IF_ID_Write_o  out  1  1 = IF/ID register updates
IF_ID_flush_o  out  1  1 = IF/ID loads a NOP
ID_EX_bubble_o  out  1  1 = ID/EX control fields zeroed
pipe_adv_o  out  1  1 = ID/EX, EX/MEM, MEM/WB update
error_o  out  1  sticky memory-timeout flag
stall_cnt_o  out  CNT_W  cycles in RUN/MEM_WAIT with PC_Write_o=0
flush_cnt_o  out  CNT_W  number of IF/ID flushes

Behaviour:
- FSM states: IDLE, RUN, MEM_WAIT, ERROR. Reset (rst_i=0, async) -> IDLE. On reset: wait_cnt=0, error_o=0, both counters 0.
- Outputs are combinational from state and inputs. In IDLE and ERROR every enable/flush/bubble/req output is 0, so the pipe is frozen.
- IDLE: start_i=1 -> RUN on the next edge.
- RUN hazard terms:
  - mem_freeze = EX_MEM_MemAccess_i & ~mem_ack_i.
  - load_use = ID_EX_MemRead_i & (ID_EX_RegisterRt_i != 0) & (Rt_ex == Rs_id | Rt_ex == Rt_id).
- RUN output priority: mem_freeze > load_use > branch_taken_i > normal.
  - mem_freeze: mem_req_o=1; PC_Write_o=IF_ID_Write_o=pipe_adv_o=0; no flush, no bubble. Next state MEM_WAIT, wait_cnt=1.
  - EX_MEM_MemAccess_i & mem_ack_i (zero-wait access): mem_req_o=1; the pipe advances normally (load_use and branch rules still apply in the same cycle).
  - load_use: PC_Write_o=0, IF_ID_Write_o=0, ID_EX_bubble_o=1, pipe_adv_o=1. Exactly one bubble per hazard. A branch taken in the same cycle is not flushed; it is re-evaluated next cycle.
  - branch_taken_i (no load_use): PC_Write_o=1, IF_ID_Write_o=1, IF_ID_flush_o=1, pipe_adv_o=1. flush_cnt_o increments.
  - normal: PC_Write_o=IF_ID_Write_o=pipe_adv_o=1.
- MEM_WAIT: mem_req_o=1 and the pipe is frozen.
  - mem_ack_i=1: outputs follow RUN rules with mem_freeze=0 in the same cycle; next state RUN; wait_cnt=0.
  - No ack and wait_cnt==MAX_WAIT: next state ERROR, error_o=1.
  - Otherwise: wait_cnt++.
- RUN with start_i=0: -> IDLE only if no MEM access is pending (EX_MEM_MemAccess_i=0 or acked this cycle). start_i is ignored in MEM_WAIT until the ack.
- ERROR is terminal until reset. mem_ack_i is ignored there.
- Counters saturate at all-ones and never wrap. stall_cnt_o increments in every RUN/MEM_WAIT cycle with PC_Write_o=0.
- Asserting reset mid-access drops mem_req_o immediately and returns to IDLE. No outstanding state survives reset.

Test Plan:
- Reset low, then start_i=1, no hazards -> IDLE outputs all 0; from cycle 1 PC_Write_o=IF_ID_Write_o=pipe_adv_o=1, counters stay 0.
- Load-use: ID_EX_MemRead_i=1, Rt_ex=5, Rs_id=5 for one cycle -> PC_Write_o=0, IF_ID_Write_o=0, ID_EX_bubble_o=1 for exactly 1 cycle; stall_cnt_o=1. Repeat with Rt_ex=0 -> no stall.
- Branch taken alone -> IF_ID_flush_o=1 one cycle, flush_cnt_o=1. Branch taken together with load-use -> bubble first, flush only when the branch is still taken next cycle.
- MEM access with ack after 3 cycles -> mem_req_o high 4 cycles, pipe frozen 3 cycles, advances on the ack cycle; stall_cnt_o=3. Zero-wait ack -> no freeze.
- MAX_WAIT=4, no ack -> ERROR entered after 5 frozen cycles; error_o=1, all enables 0; a late mem_ack_i has no effect; reset clears error_o.
- rst_i low during MEM_WAIT -> mem_req_o=0 asynchronously; state IDLE; counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for a 5-stage MIPS pipeline
// Merges load-use, taken-branch and multi-cycle memory hazards into stage enables.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RegisterRt_i,
  input  logic [4:0]       IF_ID_RegisterRs_i,
  input  logic [4:0]       IF_ID_RegisterRt_i,
  input  logic             branch_taken_i,
  input  logic             EX_MEM_MemAccess_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_bubble_o,
  output logic             pipe_adv_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_MEM_WAIT,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  logic load_use;
  logic mem_freeze;
  logic advance;
  logic active;

  assign load_use   = ID_EX_MemRead_i && (ID_EX_RegisterRt_i != 5'd0) &&
                      ((ID_EX_RegisterRt_i == IF_ID_RegisterRs_i) ||
                       (ID_EX_RegisterRt_i == IF_ID_RegisterRt_i));
  assign mem_freeze = EX_MEM_MemAccess_i && !mem_ack_i;
  assign active     = (state_q == S_RUN) || (state_q == S_MEM_WAIT);

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    error_d        = error_q;
    advance        = 1'b0;
    mem_req_o      = 1'b0;
    PC_Write_o     = 1'b0;
    IF_ID_Write_o  = 1'b0;
    IF_ID_flush_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    pipe_adv_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        mem_req_o = EX_MEM_MemAccess_i;
        if (mem_freeze) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          advance = 1'b1;
          if (!start_i) state_d = S_IDLE;
        end
      end
      S_MEM_WAIT: begin
        // start_i is deliberately ignored here: the access must finish first
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          advance    = 1'b1;
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_ERROR: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Load-use wins over a taken branch; the branch is re-evaluated next cycle.
    if (advance) begin
      pipe_adv_o = 1'b1;
      if (load_use) begin
        ID_EX_bubble_o = 1'b1;
      end else begin
        PC_Write_o    = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_ID_flush_o = branch_taken_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      error_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
      if (active && !PC_Write_o && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (IF_ID_flush_o && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign error_o     = error_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
// Vector table, directed timeout/reset/saturation sequences, random vs reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MAXW  = 4;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start, memread, br, acc, ack;
  logic [4:0] rt_ex, rs_id, rt_id;
  logic mem_req, pc_w, ifid_w, ifid_fl, bubble, adv, err;
  logic [CNTW-1:0] stall_cnt, flush_cnt;
  logic [5:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAXW), .WAIT_W(8), .CNT_W(CNTW)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .ID_EX_MemRead_i(memread), .ID_EX_RegisterRt_i(rt_ex),
    .IF_ID_RegisterRs_i(rs_id), .IF_ID_RegisterRt_i(rt_id),
    .branch_taken_i(br), .EX_MEM_MemAccess_i(acc), .mem_ack_i(ack),
    .mem_req_o(mem_req), .PC_Write_o(pc_w), .IF_ID_Write_o(ifid_w),
    .IF_ID_flush_o(ifid_fl), .ID_EX_bubble_o(bubble), .pipe_adv_o(adv),
    .error_o(err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  // {req, pc, ifid, flush, bubble, adv}
  assign outs = {mem_req, pc_w, ifid_w, ifid_fl, bubble, adv};

  typedef struct {
    logic       start, memread;
    logic [4:0] rt_ex, rs, rt;
    logic       br, acc, ack;
    logic [5:0] outs;
    int         stall, flush;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t mk(logic s, logic mr, logic [4:0] a, logic [4:0] b, logic [4:0] c,
                              logic bt, logic ac, logic ak, logic [5:0] o, int st, int fl);
    vec_t v;
    v.start = s; v.memread = mr; v.rt_ex = a; v.rs = b; v.rt = c;
    v.br = bt; v.acc = ac; v.ack = ak; v.outs = o; v.stall = st; v.flush = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(logic s, logic mr, logic [4:0] a, logic [4:0] b, logic [4:0] c,
                        logic bt, logic ac, logic ak);
    start = s; memread = mr; rt_ex = a; rs_id = b; rt_id = c; br = bt; acc = ac; ack = ak;
  endtask

  task automatic to_next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Reference model: mode 0 idle, 1 running, 2 waiting on memory, 3 dead
  int m_mode, m_wait, m_stall, m_flush;
  logic m_err;

  function automatic logic [5:0] model_outs();
    logic lu;
    logic req;
    lu = memread && (rt_ex != 0) && (rt_ex == rs_id || rt_ex == rt_id);
    if (m_mode == 0 || m_mode == 3) return 6'b000000;
    if (m_mode == 2 && !ack) return 6'b100000;
    if (m_mode == 1 && acc && !ack) return 6'b100000;
    req = (m_mode == 2) || acc;
    if (lu) return {req, 5'b00011};
    if (br) return {req, 5'b11101};
    return {req, 5'b11001};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [5:0] o;
    o = model_outs();
    if ((m_mode == 1 || m_mode == 2) && !o[4] && m_stall < CMAX) m_stall++;
    if (o[2] && m_flush < CMAX) m_flush++;
    case (m_mode)
      0: if (start) m_mode = 1;
      1: begin
        if (acc && !ack) begin m_mode = 2; m_wait = 1; end
        else if (!start) m_mode = 0;
      end
      2: begin
        if (ack) begin m_mode = 1; m_wait = 0; end
        else if (m_wait == MAXW) begin m_mode = 3; m_err = 1'b1; end
        else m_wait++;
      end
      default: ;
    endcase
  endtask

  initial begin
    int err_cycles;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs, 6'b0);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_flush", flush_cnt, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;

    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    tv[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    tv[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b011001, 0, 0);
    tv[3]  = mk(1, 1, 5, 5, 0, 0, 0, 0, 6'b000011, 0, 0);
    tv[4]  = mk(1, 0, 5, 5, 0, 0, 0, 0, 6'b011001, 1, 0);
    tv[5]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 6'b011001, 1, 0);
    tv[6]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 6'b011101, 1, 0);
    tv[7]  = mk(1, 1, 7, 0, 7, 1, 0, 0, 6'b000011, 1, 1);
    tv[8]  = mk(1, 0, 7, 0, 7, 1, 0, 0, 6'b011101, 2, 1);
    tv[9]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 6'b111001, 2, 2);
    tv[10] = mk(1, 0, 0, 0, 0, 0, 1, 0, 6'b100000, 2, 2);
    tv[11] = mk(1, 0, 0, 0, 0, 0, 1, 0, 6'b100000, 3, 2);
    tv[12] = mk(1, 0, 0, 0, 0, 0, 1, 0, 6'b100000, 4, 2);
    tv[13] = mk(1, 0, 0, 0, 0, 0, 1, 1, 6'b111001, 5, 2);
    tv[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b011001, 5, 2);
    tv[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 5, 2);

    for (int i = 0; i < 16; i++) begin
      set_in(tv[i].start, tv[i].memread, tv[i].rt_ex, tv[i].rs, tv[i].rt,
             tv[i].br, tv[i].acc, tv[i].ack);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), outs, tv[i].outs);
      chk($sformatf("vec%0d_stall", i), stall_cnt, tv[i].stall);
      chk($sformatf("vec%0d_flush", i), flush_cnt, tv[i].flush);
      to_next_cycle();
    end

    // Timeout: 5 frozen cycles then ERROR; late ack ignored; reset clears error
    reset_pulse();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    to_next_cycle();
    set_in(1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("tmo_frozen%0d", i), outs, 6'b100000);
      chk($sformatf("tmo_noerr%0d", i), err, 0);
      to_next_cycle();
    end
    @(negedge clk);
    chk("tmo_err", err, 1);
    chk("tmo_outs", outs, 6'b0);
    chk("tmo_stall", stall_cnt, 5);
    to_next_cycle();
    ack = 1'b1;
    @(negedge clk);
    chk("tmo_lateack_outs", outs, 6'b0);
    to_next_cycle();
    chk("tmo_lateack_err", err, 1);
    reset_pulse();
    chk("tmo_reset_err", err, 0);

    // Reset while waiting on memory drops the request immediately
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    to_next_cycle();
    set_in(1, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) to_next_cycle();
    chk("midwait_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_req", mem_req, 0);
    chk("midwait_rst_outs", outs, 6'b0);
    chk("midwait_rst_stall", stall_cnt, 0);
    #1;
    rst_n = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midwait_idle_outs", outs, 6'b0);
    to_next_cycle();

    // Stall counter saturation
    set_in(1, 1, 3, 0, 3, 0, 0, 0);
    repeat (CMAX + 5) to_next_cycle();
    chk("stall_sat", stall_cnt, CMAX);
    to_next_cycle();
    chk("stall_sat_hold", stall_cnt, CMAX);

    // Random stimulus against the reference model
    reset_pulse();
    model_reset();
    err_cycles = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 59) == 0 || err_cycles > 3) begin
        reset_pulse();
        model_reset();
        err_cycles = 0;
      end
      start   = ($urandom_range(0, 9) != 0);
      memread = 1'($urandom_range(0, 1));
      rt_ex   = 5'($urandom_range(0, 3));
      rs_id   = 5'($urandom_range(0, 3));
      rt_id   = 5'($urandom_range(0, 3));
      br      = ($urandom_range(0, 3) == 0);
      acc     = ($urandom_range(0, 2) == 0);
      ack     = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      chk($sformatf("rnd%0d_outs", c), outs, model_outs());
      chk($sformatf("rnd%0d_stall", c), stall_cnt, m_stall);
      chk($sformatf("rnd%0d_flush", c), flush_cnt, m_flush);
      chk($sformatf("rnd%0d_err", c), err, m_err);
      model_step();
      if (m_mode == 3) err_cycles++;
      to_next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
